hazard_stall_fsm: RTL and testbench

Parametrised hazard stall sequencer for the pipelined core, and the successor to the single-input hazard FSM. It accepts several hazard request sources and grants them by fixed priority. For each grant it holds the pipeline stall for a per-source programmable number of cycles, optionally extending while the request persists. It then emits a one-cycle flush pulse and keeps a saturating count of stalled cycles for performance statistics.

---
 rtl/hazard_stall_fsm_pkg.sv | 17 +
 rtl/hazard_stall_fsm_if.sv | 26 ++
 rtl/hazard_stall_fsm_hz_prio_enc.sv | 22 ++
 rtl/hazard_stall_fsm.sv | 93 +++++++++
 tb/tb_hazard_stall_fsm.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_fsm_pkg.sv
// Shared types and helpers for the hazard stall sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_DRAIN = 2'd2
  } statetype;

  // Lengths are carried at this width through the clamp; CNT_W must not exceed it.
  localparam int LEN_MAX_W = 16;

  function automatic logic [LEN_MAX_W-1:0] eff_len(input logic [LEN_MAX_W-1:0] len);
    return (len == '0) ? LEN_MAX_W'(1) : len;
  endfunction

endpackage

// File: rtl/hazard_stall_fsm_if.sv
// Request/status bundle between hazard sources and the stall sequencer.
interface hazard_stall_fsm_if #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4,
  parameter int STAT_W  = 16
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]       hz_req;
  logic [NUM_SRC*CNT_W-1:0] hz_len;
  logic                     kill;
  logic                     stall;
  logic                     flush;
  logic [SRC_W-1:0]         active_src;
  logic [STAT_W-1:0]        stall_cycles;

  modport master (
    output hz_req, hz_len, kill,
    input  stall, flush, active_src, stall_cycles
  );

  modport slave (
    input  hz_req, hz_len, kill,
    output stall, flush, active_src, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_fsm_hz_prio_enc.sv
// Lowest-index-first priority encoder for hazard requests.
module hz_prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  output logic                       any,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_SRC);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/hazard_stall_fsm.sv
// Multi-source hazard stall sequencer: fixed-priority grant, timed stall, flush pulse, stall statistics.
module hazard_stall_fsm
  import hazard_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int CNT_W     = 4,
  parameter int STAT_W    = 16,
  parameter int HOLD_MODE = 1
) (
  input  logic              clk,
  input  logic              hazreset_n,
  hazard_stall_fsm_if.slave hz
);
  localparam int SRC_W = $clog2(NUM_SRC);

  statetype                 state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [SRC_W-1:0]         src, src_nxt;
  logic [STAT_W-1:0]        stat;
  logic                     req_any;
  logic [SRC_W-1:0]         req_idx;
  logic [NUM_SRC*CNT_W-1:0] len_bus;
  logic [CNT_W-1:0]         len_sel;
  logic [CNT_W-1:0]         len_eff;

  hz_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .req (hz.hz_req),
    .any (req_any),
    .idx (req_idx)
  );

  assign len_bus = hz.hz_len;
  assign len_sel = len_bus[req_idx*CNT_W +: CNT_W];
  assign len_eff = CNT_W'(eff_len(LEN_MAX_W'(len_sel)));

  always_ff @(posedge clk or negedge hazreset_n) begin
    if (!hazreset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      src   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      src   <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = src;
    case (state)
      S_IDLE, S_DRAIN: begin
        if (req_any) begin
          state_nxt = S_STALL;
          src_nxt   = req_idx;
          cnt_nxt   = len_eff;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_STALL: begin
        if (cnt > CNT_W'(1)) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if ((HOLD_MODE != 0) && hz.hz_req[src]) begin
          cnt_nxt = cnt;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort beats any grant or hold decided above; the last grant index is kept.
    if (hz.kill) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      src_nxt   = src;
    end
  end

  always_ff @(posedge clk or negedge hazreset_n) begin
    if (!hazreset_n) begin
      stat <= '0;
    end else if ((state == S_STALL) && (stat != '1)) begin
      stat <= stat + STAT_W'(1);
    end
  end

  assign hz.stall        = (state == S_STALL);
  assign hz.flush        = (state == S_DRAIN);
  assign hz.active_src   = src;
  assign hz.stall_cycles = stat;
endmodule

// File: tb/tb_hazard_stall_fsm.sv
// Scoreboard bench: dut_a runs HOLD_MODE=1/STAT_W=16, dut_b runs HOLD_MODE=0/STAT_W=4.
module tb_hazard_stall_fsm;
  logic clk = 1'b0;
  logic hazreset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [1:0] src;
  } exp_t;

  exp_t q[$];

  hazard_stall_fsm_if #(.NUM_SRC(4), .CNT_W(4), .STAT_W(16)) hz_a ();
  hazard_stall_fsm_if #(.NUM_SRC(4), .CNT_W(4), .STAT_W(4))  hz_b ();

  hazard_stall_fsm #(.NUM_SRC(4), .CNT_W(4), .STAT_W(16), .HOLD_MODE(1)) dut_a (
    .clk(clk), .hazreset_n(hazreset_n), .hz(hz_a)
  );
  hazard_stall_fsm #(.NUM_SRC(4), .CNT_W(4), .STAT_W(4), .HOLD_MODE(0)) dut_b (
    .clk(clk), .hazreset_n(hazreset_n), .hz(hz_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void push(input logic s, input logic f, input logic [1:0] src, input int n);
    for (int i = 0; i < n; i++) q.push_back({s, f, src});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hz_a.hz_req = '0; hz_a.hz_len = '0; hz_a.kill = 1'b0;
    hz_b.hz_req = '0; hz_b.hz_len = '0; hz_b.kill = 1'b0;
    q.delete();
    hazreset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 hazreset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hz_a.stall !== 1'b0 || hz_a.flush !== 1'b0 || hz_a.active_src !== 2'd0 || hz_a.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_a got s=%b f=%b src=%0d cyc=%0d required all zero",
               hz_a.stall, hz_a.flush, hz_a.active_src, hz_a.stall_cycles);
    end
    checks++;
    if (hz_b.stall !== 1'b0 || hz_b.flush !== 1'b0 || hz_b.active_src !== 2'd0 || hz_b.stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL reset_b got s=%b f=%b src=%0d cyc=%0d required all zero",
               hz_b.stall, hz_b.flush, hz_b.active_src, hz_b.stall_cycles);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    hz_b.hz_len = 16'h0300;
    hz_b.hz_req = 4'b0100;
    push(0, 0, 0, 1); push(1, 0, 2, 3); push(0, 1, 0, 1); push(0, 0, 0, 2);
    for (int cyc = 0; q.size() > 0; cyc++) begin
      if (cyc == 1) hz_b.hz_req = 4'b0000;
      e = q.pop_front();
      checks++;
      if (hz_b.stall !== e.stall || hz_b.flush !== e.flush || (e.stall && hz_b.active_src !== e.src)) begin
        errors++;
        $display("FAIL single cyc=%0d got s=%b f=%b src=%0d required s=%b f=%b src=%0d",
                 cyc, hz_b.stall, hz_b.flush, hz_b.active_src, e.stall, e.flush, e.src);
      end
      step();
    end
    checks++;
    if (hz_b.stall_cycles !== 4'd3) begin
      errors++;
      $display("FAIL single_stat got %0d required 3", hz_b.stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    hz_b.hz_len = 16'h5020;
    hz_b.hz_req = 4'b1010;
    push(0, 0, 0, 1); push(1, 0, 1, 2); push(0, 1, 0, 1);
    push(1, 0, 3, 5); push(0, 1, 0, 1); push(0, 0, 0, 2);
    for (int cyc = 0; q.size() > 0; cyc++) begin
      if (cyc == 1) hz_b.hz_req = 4'b1000;
      if (cyc == 4) hz_b.hz_req = 4'b0000;
      e = q.pop_front();
      checks++;
      if (hz_b.stall !== e.stall || hz_b.flush !== e.flush || (e.stall && hz_b.active_src !== e.src)) begin
        errors++;
        $display("FAIL b2b cyc=%0d got s=%b f=%b src=%0d required s=%b f=%b src=%0d",
                 cyc, hz_b.stall, hz_b.flush, hz_b.active_src, e.stall, e.flush, e.src);
      end
      step();
    end
    checks++;
    if (hz_b.stall_cycles !== 4'd7) begin
      errors++;
      $display("FAIL b2b_stat got %0d required 7", hz_b.stall_cycles);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    hz_a.hz_len = 16'h0000;
    hz_a.hz_req = 4'b0001;
    push(0, 0, 0, 1); push(1, 0, 0, 6); push(0, 1, 0, 1); push(0, 0, 0, 2);
    for (int cyc = 0; q.size() > 0; cyc++) begin
      if (cyc == 6) hz_a.hz_req = 4'b0000;
      e = q.pop_front();
      checks++;
      if (hz_a.stall !== e.stall || hz_a.flush !== e.flush || (e.stall && hz_a.active_src !== e.src)) begin
        errors++;
        $display("FAIL hold cyc=%0d got s=%b f=%b src=%0d required s=%b f=%b src=%0d",
                 cyc, hz_a.stall, hz_a.flush, hz_a.active_src, e.stall, e.flush, e.src);
      end
      step();
    end
    checks++;
    if (hz_a.stall_cycles !== 16'd6) begin
      errors++;
      $display("FAIL hold_stat got %0d required 6", hz_a.stall_cycles);
    end
  endtask

  task automatic test_kill();
    exp_t e;
    do_reset();
    hz_b.hz_len = 16'h0040;
    hz_b.hz_req = 4'b0010;
    push(0, 0, 0, 1); push(1, 0, 1, 2); push(0, 0, 0, 4);
    for (int cyc = 0; q.size() > 0; cyc++) begin
      if (cyc == 1) hz_b.hz_req = 4'b0000;
      if (cyc == 2) hz_b.kill = 1'b1;
      if (cyc == 3) hz_b.kill = 1'b0;
      if (cyc == 4) begin hz_b.hz_req = 4'b0001; hz_b.kill = 1'b1; end
      if (cyc == 5) begin hz_b.hz_req = 4'b0000; hz_b.kill = 1'b0; end
      e = q.pop_front();
      checks++;
      if (hz_b.stall !== e.stall || hz_b.flush !== e.flush || (e.stall && hz_b.active_src !== e.src)) begin
        errors++;
        $display("FAIL kill cyc=%0d got s=%b f=%b src=%0d required s=%b f=%b src=%0d",
                 cyc, hz_b.stall, hz_b.flush, hz_b.active_src, e.stall, e.flush, e.src);
      end
      step();
    end
    checks++;
    if (hz_b.stall_cycles !== 4'd2) begin
      errors++;
      $display("FAIL kill_stat got %0d required 2", hz_b.stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    hz_a.hz_len = 16'h5000;
    hz_a.hz_req = 4'b1000;
    step();
    hz_a.hz_req = 4'b0000;
    step();
    checks++;
    if (hz_a.stall !== 1'b1 || hz_a.active_src !== 2'd3) begin
      errors++;
      $display("FAIL arst_pre got s=%b src=%0d required s=1 src=3", hz_a.stall, hz_a.active_src);
    end
    #2 hazreset_n = 1'b0;
    #1;
    checks++;
    if (hz_a.stall !== 1'b0 || hz_a.flush !== 1'b0 || hz_a.active_src !== 2'd0 || hz_a.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL arst_mid got s=%b f=%b src=%0d cyc=%0d required all zero",
               hz_a.stall, hz_a.flush, hz_a.active_src, hz_a.stall_cycles);
    end
    #2 hazreset_n = 1'b1;
    hz_a.hz_len = 16'h0010;
    hz_a.hz_req = 4'b0010;
    step();
    hz_a.hz_req = 4'b0000;
    checks++;
    if (hz_a.stall !== 1'b1 || hz_a.active_src !== 2'd1) begin
      errors++;
      $display("FAIL arst_first_grant got s=%b src=%0d required s=1 src=1", hz_a.stall, hz_a.active_src);
    end
    step();
    checks++;
    if (hz_a.stall !== 1'b0 || hz_a.flush !== 1'b1) begin
      errors++;
      $display("FAIL arst_flush got s=%b f=%b required s=0 f=1", hz_a.stall, hz_a.flush);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   exp_stat;
    do_reset();
    exp_stat = 0;
    hz_b.hz_len = 16'h0004;
    hz_b.hz_req = 4'b0001;
    push(0, 0, 0, 1);
    for (int g = 0; g < 5; g++) begin
      push(1, 0, 0, 4);
      push(0, 1, 0, 1);
    end
    push(0, 0, 0, 2);
    for (int cyc = 0; q.size() > 0; cyc++) begin
      if (cyc == 21) hz_b.hz_req = 4'b0000;
      e = q.pop_front();
      checks++;
      if (hz_b.stall !== e.stall || hz_b.flush !== e.flush ||
          hz_b.stall_cycles !== 4'(exp_stat)) begin
        errors++;
        $display("FAIL sat cyc=%0d got s=%b f=%b cnt=%0d required s=%b f=%b cnt=%0d",
                 cyc, hz_b.stall, hz_b.flush, hz_b.stall_cycles, e.stall, e.flush, exp_stat);
      end
      if (e.stall && exp_stat < 15) exp_stat++;
      step();
    end
    checks++;
    if (hz_b.stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat_final got %0d required 15", hz_b.stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_kill();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
